// File: rtl/video_timing_gen.sv
// video_timing_gen
// Parametrised raster timing generator. A free-running pixel/line counter pair
// is decoded into sync, blank, border, window coordinates, renderer requests
// and interrupts. Every output is registered from the counter state of the
// previous cycle, so all outputs share a uniform 1-clock latency.
//
// Ports:
//   clk              pixel clock
//   reset            synchronous, active-high
//   left_col_blank   forces scaled columns WIN_X..WIN_X+7 to border
//   line_irq_en      enables the line-compare interrupt
//   line_irq_line    compare value (window line number)
//   hpos / vpos      window pixel column / window line (modulo 2^POS_W)
//   hsync / vsync    sync outputs at the configured polarity
//   blank            outside the H_ACTIVE x V_ACTIVE area
//   border           inside the active area but outside the window
//   next_line        1-clk pulse at the end of each scaled line
//   frame_start      1-clk pulse on the last clock of the frame
//   render_line      line the renderer must produce next
//   render_start     1-clk pulse telling the renderer to begin render_line
//   vblank_irq_pulse 1-clk pulse when window line WIN_H-1 completes
//   line_irq_pulse   1-clk pulse when the compared window line completes
module video_timing_gen #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter bit HSYNC_POL    = 1'b0,
    parameter bit VSYNC_POL    = 1'b0,
    parameter int H_SCALE      = 2,
    parameter int V_SCALE      = 2,
    parameter int WIN_X        = 32,
    parameter int WIN_Y        = 24,
    parameter int WIN_W        = 256,
    parameter int WIN_H        = 192,
    parameter int RENDER_AHEAD = 1,
    parameter int POS_W        = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             left_col_blank,
    input  logic             line_irq_en,
    input  logic [POS_W-1:0] line_irq_line,
    output logic [POS_W-1:0] hpos,
    output logic [POS_W-1:0] vpos,
    output logic             hsync,
    output logic             vsync,
    output logic             blank,
    output logic             border,
    output logic             next_line,
    output logic             frame_start,
    output logic [POS_W-1:0] render_line,
    output logic             render_start,
    output logic             vblank_irq_pulse,
    output logic             line_irq_pulse
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HCW     = $clog2(H_TOTAL);
    localparam int VCW     = $clog2(V_TOTAL);
    localparam int AW0     = (HCW > VCW) ? HCW : VCW;
    // Arithmetic width: wide enough for either counter, the position outputs
    // and the totals themselves, so no compare bound can wrap.
    localparam int AW      = ((AW0 > POS_W) ? AW0 : POS_W) + 1;
    localparam int H_SHIFT = (H_SCALE == 4) ? 2 : (H_SCALE == 2) ? 1 : 0;
    localparam int V_SHIFT = (V_SCALE == 4) ? 2 : (V_SCALE == 2) ? 1 : 0;

    logic [HCW-1:0] hcnt;
    logic [VCW-1:0] vcnt;
    logic           hlast;
    logic           vlast;

    assign hlast = (hcnt == HCW'(H_TOTAL - 1));
    assign vlast = (vcnt == VCW'(V_TOTAL - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hlast) begin
            hcnt <= '0;
            vcnt <= vlast ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    // ---- stage p0: combinational decode of the current counter state ----
    logic [AW-1:0]    hs_p0;
    logic [AW-1:0]    vs_p0;
    logic [AW-1:0]    win_x_lo_p0;
    logic             vsub_last_p0;
    logic             blank_p0;
    logic             hsync_act_p0;
    logic             vsync_act_p0;
    logic             in_win_h_p0;
    logic             in_win_v_p0;
    logic             border_p0;
    logic [POS_W-1:0] hpos_p0;
    logic [POS_W-1:0] vpos_p0;
    logic [POS_W-1:0] rline_p0;
    logic             next_p0;
    logic             frame_p0;
    logic             rstart_p0;
    logic             vblank_p0;
    logic             lirq_p0;

    always_comb begin
        hs_p0        = AW'(hcnt) >> H_SHIFT;
        vs_p0        = AW'(vcnt) >> V_SHIFT;
        // With V_SCALE = 1 the mask is zero, so every line is a scaled-line end.
        vsub_last_p0 = ((vcnt & VCW'(V_SCALE - 1)) == VCW'(V_SCALE - 1));

        blank_p0     = (AW'(hcnt) >= AW'(H_ACTIVE)) || (AW'(vcnt) >= AW'(V_ACTIVE));
        hsync_act_p0 = (AW'(hcnt) >= AW'(H_ACTIVE + H_FP)) &&
                       (AW'(hcnt) <  AW'(H_ACTIVE + H_FP + H_SYNC));
        vsync_act_p0 = (AW'(vcnt) >= AW'(V_ACTIVE + V_FP)) &&
                       (AW'(vcnt) <  AW'(V_ACTIVE + V_FP + V_SYNC));

        win_x_lo_p0  = AW'(WIN_X) + (left_col_blank ? AW'(8) : AW'(0));
        in_win_h_p0  = (hs_p0 >= win_x_lo_p0) && (hs_p0 < AW'(WIN_X + WIN_W));
        in_win_v_p0  = (vs_p0 >= AW'(WIN_Y)) && (vs_p0 < AW'(WIN_Y + WIN_H));
        border_p0    = !blank_p0 && !(in_win_h_p0 && in_win_v_p0);

        hpos_p0      = in_win_h_p0 ? POS_W'(hs_p0 - AW'(WIN_X)) : '0;
        // Deliberately wraps above the window so the top border reads large.
        vpos_p0      = POS_W'(vs_p0 - AW'(WIN_Y));

        next_p0      = hlast && vsub_last_p0;
        frame_p0     = hlast && vlast;

        // Line the renderer needs RENDER_AHEAD scaled lines from now.
        rline_p0     = POS_W'(vs_p0 + AW'(RENDER_AHEAD) - AW'(WIN_Y));
        rstart_p0    = next_p0 && (AW'(rline_p0) < AW'(WIN_H));
        vblank_p0    = next_p0 && (vpos_p0 == POS_W'(WIN_H - 1));
        lirq_p0      = next_p0 && line_irq_en && (vpos_p0 == line_irq_line);
    end

    // ---- stage p1: registered outputs ----
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync            <= ~HSYNC_POL;
            vsync            <= ~VSYNC_POL;
            blank            <= 1'b1;
            border           <= 1'b0;
            hpos             <= '0;
            vpos             <= '0;
            render_line      <= '0;
            next_line        <= 1'b0;
            frame_start      <= 1'b0;
            render_start     <= 1'b0;
            vblank_irq_pulse <= 1'b0;
            line_irq_pulse   <= 1'b0;
        end else begin
            hsync            <= hsync_act_p0 ? HSYNC_POL : ~HSYNC_POL;
            vsync            <= vsync_act_p0 ? VSYNC_POL : ~VSYNC_POL;
            blank            <= blank_p0;
            border           <= border_p0;
            hpos             <= hpos_p0;
            vpos             <= vpos_p0;
            if (next_p0) begin
                render_line <= rline_p0;
            end
            next_line        <= next_p0;
            frame_start      <= frame_p0;
            render_start     <= rstart_p0;
            vblank_irq_pulse <= vblank_p0;
            line_irq_pulse   <= lirq_p0;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen
// Directed bench for video_timing_gen using a reduced raster so whole frames
// fit in a short run:
//   H: 40 active, 4 FP, 6 sync, 6 BP  -> 56 clks/line, hsync active low
//   V: 30 active, 3 FP, 2 sync, 4 BP  -> 39 lines/frame, vsync active high
//   scale 2x2, window origin (3,2) scaled, size 12x10 scaled, render ahead 1
// Sample point "state (h,v)" is #1 after the posedge whose output shows
// counter state hcnt=h, vcnt=v; idx counts those states from reset release.
module tb_video_timing_gen;

    localparam int HT = 56;
    localparam int VT = 39;
    localparam int FT = HT * VT;   // 2184 clks per frame

    logic       clk = 1'b0;
    logic       reset;
    logic       left_col_blank;
    logic       line_irq_en;
    logic [8:0] line_irq_line;
    logic [8:0] hpos, vpos, render_line;
    logic       hsync, vsync, blank, border, next_line, frame_start;
    logic       render_start, vblank_irq_pulse, line_irq_pulse;

    int ncmp  = 0;
    int nfail = 0;
    int idx   = 0;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(30), .V_FP(3), .V_SYNC(2), .V_BP(4),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b1),
        .H_SCALE(2), .V_SCALE(2),
        .WIN_X(3), .WIN_Y(2), .WIN_W(12), .WIN_H(10),
        .RENDER_AHEAD(1), .POS_W(9)
    ) dut (
        .clk(clk), .reset(reset),
        .left_col_blank(left_col_blank),
        .line_irq_en(line_irq_en), .line_irq_line(line_irq_line),
        .hpos(hpos), .vpos(vpos), .hsync(hsync), .vsync(vsync),
        .blank(blank), .border(border), .next_line(next_line),
        .frame_start(frame_start), .render_line(render_line),
        .render_start(render_start), .vblank_irq_pulse(vblank_irq_pulse),
        .line_irq_pulse(line_irq_pulse)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idx++;
    endtask

    task automatic goto_st(input int f, input int v, input int h);
        int t;
        t = f * FT + v * HT + h;
        while (idx < t) tick();
    endtask

    task automatic check_reset_vals(input string p);
        chk({p, "_hsync"}, hsync, 1);
        chk({p, "_vsync"}, vsync, 0);
        chk({p, "_blank"}, blank, 1);
        chk({p, "_border"}, border, 0);
        chk({p, "_hpos"}, hpos, 0);
        chk({p, "_vpos"}, vpos, 0);
        chk({p, "_render_line"}, render_line, 0);
        chk({p, "_next_line"}, next_line, 0);
        chk({p, "_frame_start"}, frame_start, 0);
        chk({p, "_render_start"}, render_start, 0);
        chk({p, "_vblank_irq"}, vblank_irq_pulse, 0);
        chk({p, "_line_irq"}, line_irq_pulse, 0);
    endtask

    // Walk one whole frame f (left_col_blank=0) and check per-frame totals.
    task automatic run_frame(input int f, input int exp_lirq);
        int n_rs, n_vb, n_li, n_fs, n_nl, n_hs, n_vs, n_act, n_win, exp_rl;
        n_rs = 0; n_vb = 0; n_li = 0; n_fs = 0; n_nl = 0;
        n_hs = 0; n_vs = 0; n_act = 0; n_win = 0; exp_rl = 0;
        for (int t = f * FT; t < (f + 1) * FT; t++) begin
            goto_st(0, 0, t);
            if (render_start) begin
                chk("frame_render_line_seq", render_line, exp_rl);
                exp_rl++;
                n_rs++;
            end
            if (line_irq_pulse) begin
                chk("frame_lirq_with_vblank", vblank_irq_pulse, 1);
                n_li++;
            end
            if (frame_start) begin
                chk("frame_start_position", idx, f * FT + FT - 1);
                n_fs++;
            end
            if (vblank_irq_pulse) n_vb++;
            if (next_line) n_nl++;
            if (!hsync) n_hs++;
            if (vsync) n_vs++;
            if (!blank) n_act++;
            if (!blank && !border) n_win++;
        end
        chk("frame_render_start_count", n_rs, 10);
        chk("frame_vblank_count", n_vb, 1);
        chk("frame_line_irq_count", n_li, exp_lirq);
        chk("frame_start_count", n_fs, 1);
        chk("frame_next_line_count", n_nl, 19);
        chk("frame_hsync_low_clks", n_hs, 6 * VT);
        chk("frame_vsync_act_clks", n_vs, 2 * HT);
        chk("frame_active_clks", n_act, 40 * 30);
        chk("frame_window_clks", n_win, 24 * 20);
    endtask

    initial begin
        int n;
        reset          = 1'b1;
        left_col_blank = 1'b0;
        line_irq_en    = 1'b1;
        line_irq_line  = 9'd5;

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst0");

        reset = 1'b0;
        idx   = -1;
        tick();
        // State (0,0): top border, vpos wraps to 0-2.
        chk("s00_blank", blank, 0);
        chk("s00_border", border, 1);
        chk("s00_hpos", hpos, 0);
        chk("s00_vpos", vpos, 510);
        chk("s00_hsync", hsync, 1);
        chk("s00_vsync", vsync, 0);
        chk("s00_next_line", next_line, 0);

        goto_st(0, 0, 39); chk("blank_h39", blank, 0);
        goto_st(0, 0, 40); chk("blank_h40", blank, 1);
        goto_st(0, 0, 43); chk("hsync_h43", hsync, 1);
        goto_st(0, 0, 44); chk("hsync_h44", hsync, 0);
        goto_st(0, 0, 49); chk("hsync_h49", hsync, 0);
        goto_st(0, 0, 50); chk("hsync_h50", hsync, 1);
        goto_st(0, 0, 55); chk("next_line_v0", next_line, 0);
        goto_st(0, 1, 54); chk("next_line_h54v1", next_line, 0);
        goto_st(0, 1, 55);
        chk("next_line_v1", next_line, 1);
        chk("render_line_v1", render_line, 511);
        chk("render_start_v1", render_start, 0);
        goto_st(0, 3, 55);
        chk("render_start_v3", render_start, 1);
        chk("render_line_v3", render_line, 0);

        goto_st(0, 4, 5);  chk("win_h5_border", border, 1);
        goto_st(0, 4, 6);
        chk("win_h6_border", border, 0);
        chk("win_h6_hpos", hpos, 0);
        chk("win_v4_vpos", vpos, 0);
        goto_st(0, 4, 8);  chk("win_h8_hpos", hpos, 1);
        goto_st(0, 4, 29);
        chk("win_h29_hpos", hpos, 11);
        chk("win_h29_border", border, 0);
        goto_st(0, 4, 30);
        chk("win_h30_border", border, 1);
        chk("win_h30_hpos", hpos, 0);
        goto_st(0, 6, 10); chk("win_v6_vpos", vpos, 1);

        goto_st(0, 13, 55); chk("lirq_v13", line_irq_pulse, 0);
        goto_st(0, 15, 55);
        chk("lirq_v15", line_irq_pulse, 1);
        chk("vblank_v15", vblank_irq_pulse, 0);
        goto_st(0, 21, 55);
        chk("render_start_v21", render_start, 1);
        chk("render_line_v21", render_line, 9);
        goto_st(0, 23, 55);
        chk("vblank_v23", vblank_irq_pulse, 1);
        chk("render_start_v23", render_start, 0);
        chk("render_line_v23", render_line, 10);
        chk("lirq_v23", line_irq_pulse, 0);
        goto_st(0, 24, 10);
        chk("bottom_border", border, 1);
        chk("bottom_vpos", vpos, 10);
        goto_st(0, 30, 10);
        chk("vblank_area_blank", blank, 1);
        chk("vblank_area_border", border, 0);
        goto_st(0, 32, 0); chk("vsync_v32", vsync, 0);
        goto_st(0, 33, 0); chk("vsync_v33", vsync, 1);
        goto_st(0, 34, 0); chk("vsync_v34", vsync, 1);
        goto_st(0, 35, 0); chk("vsync_v35", vsync, 0);
        goto_st(0, 38, 54); chk("frame_start_h54", frame_start, 0);
        goto_st(0, 38, 55); chk("frame_start_last", frame_start, 1);

        // Frame 1: compare on the last window line, coinciding with vblank IRQ.
        line_irq_line = 9'd9;
        run_frame(1, 1);

        // Frame 2: left column blanking, 1-clk latency, hpos/border only.
        goto_st(2, 4, 6);
        chk("lcb_before_border", border, 0);
        left_col_blank = 1'b1;
        tick();
        chk("lcb_h7_border", border, 1);
        chk("lcb_h7_hpos", hpos, 0);
        chk("lcb_h7_blank", blank, 0);
        goto_st(2, 4, 21); chk("lcb_h21_border", border, 1);
        goto_st(2, 4, 22);
        chk("lcb_h22_border", border, 0);
        chk("lcb_h22_hpos", hpos, 8);
        goto_st(2, 4, 44); chk("lcb_hsync", hsync, 0);
        left_col_blank = 1'b0;
        line_irq_en    = 1'b0;

        // Frame 3: interrupt disabled.
        goto_st(3, 0, -1);
        run_frame(3, 0);

        // Frame 4: mid-frame reset for 3 clocks.
        goto_st(4, 10, 20);
        reset = 1'b1;
        repeat (3) tick();
        check_reset_vals("rst1");
        reset = 1'b0;
        idx   = -1;
        tick();
        chk("rst1_s00_blank", blank, 0);
        chk("rst1_s00_border", border, 1);
        chk("rst1_s00_vpos", vpos, 510);
        chk("rst1_s00_render_line", render_line, 0);
        n = -1;
        for (int k = 0; k < 3000; k++) begin
            if (frame_start) begin
                n = idx;
                break;
            end
            tick();
        end
        chk("rst1_frame_start_idx", n, FT - 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
